vram_pingpong: RTL and testbench
================================

# vram_pingpong

Parametrised double-buffered video RAM for the camera capture path, successor to the single-word dummy frame store. A camera writer fills one bank while the display/SD reader scans the other; banks swap on frame boundaries under a small state machine, so the reader never sees a partially written frame. Single clock domain, one write port, one registered read port.

## Interface

- DW, 12, pixel width in bits (RGB444)
- AW, 14, address width per bank (bank depth 2**AW words)
- FRAME_WORDS, 16384, valid words per frame; 1 ≤ FRAME_WORDS ≤ 2**AW

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe, effective only when wr_ready=1
- wr_addr  in  AW  write address within write bank
- wr_data  in  DW  write pixel
- wr_frame_end  in  1  one-cycle pulse: writer finished current frame
- wr_ready  out  1  write bank accepts data
- rd_en  in  1  read strobe
- rd_addr  in  AW  read address within read bank
- rd_data  out  DW  read pixel, registered
- rd_valid  out  1  rd_data updated this cycle
- rd_frame_end  in  1  one-cycle pulse: reader finished scanning current frame
- frame_ready  out  1  read bank holds a complete frame
- wr_bank  out  1  bank currently written
- rd_bank  out  1  bank currently read; always ~wr_bank
- overrun  out  1  sticky: a completed frame was discarded

## Operation

- States: EMPTY (no complete frame for reader), FULL (read bank complete, writer filling other bank), PEND (both banks complete, reader still busy).
- EMPTY: wr_frame_end → swap banks, FULL. rd_frame_end ignored.
- FULL: wr_frame_end only → PEND. rd_frame_end only → EMPTY (no swap). Both same cycle → swap, stay FULL.
- PEND: writes blocked (wr_ready=0, wr_en ignored). rd_frame_end → swap, FULL. wr_frame_end → set overrun, stay PEND. Both same cycle → swap, FULL, overrun not set.
- frame_ready = 1 in FULL and PEND; wr_ready = 0 only in PEND.
- Writes with wr_addr ≥ FRAME_WORDS dropped silently.
- Reads with rd_addr ≥ FRAME_WORDS return 0 with rd_valid=1.
- Reading in EMPTY is allowed; returns stale contents of rd_bank.
- No read/write collision: rd_bank ≠ wr_bank at all times.
- overrun clears only on rst.

## Timing

- Reset values: state EMPTY, wr_bank=0, rd_bank=1, rd_data=0, rd_valid=0, frame_ready=0, wr_ready=1, overrun=0. RAM contents not reset.
- Write: data stored at the clk edge where wr_en=1 and wr_ready=1; visible to reads after the bank swaps.
- Read latency 1: rd_en at edge N → rd_data/rd_valid at N+1. rd_valid=0 when rd_en=0; rd_data holds last value.
- Swap cycle: bank select for a read or write issued in the swap cycle uses pre-swap banks; new banks apply from the next cycle.
- State/flag outputs registered, change one cycle after the triggering pulse.
- rst mid-frame: returns to reset values next edge; pending frame abandoned.

## Structure

- Package vram_pkg: state enum (EMPTY, FULL, PEND), default DW/AW/FRAME_WORDS constants.
- Sub-module vram_dpram: simple dual-port RAM, depth 2**(AW+1), width DW, registered read; bank bit is the address MSB. Top holds FSM, bank bits, range checks, flags.

## Test plan

- Reset, write 0x0AB at addr 5, pulse wr_frame_end → frame_ready=1, rd_bank=0; read addr 5 → rd_data=0x0AB one cycle later.
- FULL, writer finishes second frame (0x123 at addr 5) → PEND, wr_ready=0; write 0xFFF dropped; rd_frame_end → swap, read addr 5 = 0x123.
- PEND + second wr_frame_end → overrun=1, remains 1 until rst.
- FULL with wr_frame_end and rd_frame_end same cycle → banks swap, state FULL, overrun=0.
- FRAME_WORDS=100: write addr 100 dropped, read addr 100 → 0; addr 99 round-trips.
- rst asserted in PEND → all outputs at reset values next cycle; subsequent frame cycle works normally.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and default sizing for the ping-pong video RAM.
package vram_pkg;

  // Frame-buffer ownership states
  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // reader has no complete frame
    FULL  = 2'd1,  // read bank complete, writer filling the other bank
    PEND  = 2'd2   // both banks complete, reader still scanning
  } state_t;

  localparam int DEF_DW          = 12;     // RGB444 pixel
  localparam int DEF_AW          = 14;     // words per bank = 2**AW
  localparam int DEF_FRAME_WORDS = 16384;  // valid words per frame

  // True when a word address lies inside the active frame area
  function automatic logic addr_in_frame(input int unsigned addr,
                                         input int unsigned frame_words);
    return addr < frame_words;
  endfunction

endpackage

// File: rtl/vram_pingpong_if.sv
// Writer/reader bus of the ping-pong video RAM.
// The master modport belongs to the camera writer plus display reader;
// the slave modport belongs to the frame store.
interface vram_pingpong_if #(
  parameter int DW = vram_pkg::DEF_DW,
  parameter int AW = vram_pkg::DEF_AW
);
  // write side
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_frame_end;
  logic          wr_ready;
  // read side
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_frame_end;
  // status
  logic          frame_ready;
  logic          wr_bank;
  logic          rd_bank;
  logic          overrun;

  modport master (
    output wr_en, wr_addr, wr_data, wr_frame_end,
    output rd_en, rd_addr, rd_frame_end,
    input  wr_ready, rd_data, rd_valid,
    input  frame_ready, wr_bank, rd_bank, overrun
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_frame_end,
    input  rd_en, rd_addr, rd_frame_end,
    output wr_ready, rd_data, rd_valid,
    output frame_ready, wr_bank, rd_bank, overrun
  );

endinterface

// File: rtl/vram_dpram.sv
// Simple dual-port RAM holding both banks: one write port, one registered
// read port. The bank select is the address MSB. Contents are not reset.
module vram_dpram #(
  parameter int DW = 12,
  parameter int AW = 14   // per-bank address width; total depth 2**(AW+1)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW:0]   i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW:0]   i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 2 ** (AW + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // Write port plus registered read port; read holds its value when idle
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/vram_pingpong.sv
// Double-buffered video RAM: the camera fills one bank while the reader
// scans the other; banks swap on frame boundaries so the reader never sees
// a partially written frame.
module vram_pingpong
  import vram_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input logic            clk,
  input logic            rst,
  vram_pingpong_if.slave bus
);

  state_t        r_state;
  state_t        w_state_next;
  logic          w_swap;
  logic          w_overrun_set;

  logic          r_wr_bank;
  logic          r_overrun;
  logic          r_frame_ready;
  logic          r_wr_ready;
  logic          r_rd_valid;
  logic          r_rd_zero;     // forces rd_data to 0 after reset / out-of-frame read

  logic          w_wr_in_range;
  logic          w_rd_in_range;
  logic          w_we;
  logic [DW-1:0] w_ram_q;

  assign w_wr_in_range = addr_in_frame(32'(bus.wr_addr), FRAME_WORDS);
  assign w_rd_in_range = addr_in_frame(32'(bus.rd_addr), FRAME_WORDS);

  // Writes are blocked while both banks hold complete frames
  assign w_we = bus.wr_en && r_wr_ready && w_wr_in_range;

  // Bank ownership FSM: next state, swap request and overrun detection
  always_comb begin
    w_state_next  = r_state;
    w_swap        = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      EMPTY: begin
        if (bus.wr_frame_end) begin
          w_swap       = 1'b1;
          w_state_next = FULL;
        end
      end
      FULL: begin
        case ({bus.wr_frame_end, bus.rd_frame_end})
          2'b10:   w_state_next = PEND;
          2'b01:   w_state_next = EMPTY;
          2'b11: begin
            w_swap       = 1'b1;
            w_state_next = FULL;
          end
          default: w_state_next = FULL;
        endcase
      end
      PEND: begin
        if (bus.rd_frame_end) begin
          // reader done: hand it the waiting frame, even if a new one just ended
          w_swap       = 1'b1;
          w_state_next = FULL;
        end else if (bus.wr_frame_end) begin
          // writer could not write, so this "frame" is discarded
          w_overrun_set = 1'b1;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bank select and registered status flags, updated from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank     <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_ready <= 1'b0;
      r_wr_ready    <= 1'b1;
    end else begin
      r_wr_bank     <= r_wr_bank ^ w_swap;
      r_overrun     <= r_overrun | w_overrun_set;
      r_frame_ready <= (w_state_next != EMPTY);
      r_wr_ready    <= (w_state_next != PEND);
    end
  end

  // Read strobe pipeline; out-of-frame reads are masked to zero at the output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_zero <= !w_rd_in_range;
      end
    end
  end

  // Both ports use the pre-swap bank in a swap cycle since r_wr_bank is registered
  vram_dpram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({r_wr_bank, bus.wr_addr}),
    .i_wdata (bus.wr_data),
    .i_re    (bus.rd_en),
    .i_raddr ({~r_wr_bank, bus.rd_addr}),
    .o_rdata (w_ram_q)
  );

  assign bus.wr_ready    = r_wr_ready;
  assign bus.rd_data     = r_rd_zero ? '0 : w_ram_q;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.frame_ready = r_frame_ready;
  assign bus.wr_bank     = r_wr_bank;
  assign bus.rd_bank     = ~r_wr_bank;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_vram_pingpong.sv
// Directed bench for the ping-pong video RAM (small banks, FRAME_WORDS=100).
module tb_vram_pingpong;

  localparam int DW = 12;
  localparam int AW = 7;
  localparam int FW = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  vram_pingpong_if #(.DW(DW), .AW(AW)) bus ();

  vram_pingpong #(
    .DW          (DW),
    .AW          (AW),
    .FRAME_WORDS (FW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Count one comparison and report it on a single line
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-18s got 0x%0h", tag, got);
    end else begin
      $display("FAIL %-18s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs sampled and inputs driven 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse(input logic wfe, input logic rfe);
    bus.wr_frame_end = wfe; bus.rd_frame_end = rfe;
    tick();
    bus.wr_frame_end = 1'b0; bus.rd_frame_end = 1'b0;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_frame_ready"}, 32'(bus.frame_ready), 0);
    chk({pfx, "_wr_ready"},    32'(bus.wr_ready),    1);
    chk({pfx, "_wr_bank"},     32'(bus.wr_bank),     0);
    chk({pfx, "_rd_bank"},     32'(bus.rd_bank),     1);
    chk({pfx, "_overrun"},     32'(bus.overrun),     0);
    chk({pfx, "_rd_valid"},    32'(bus.rd_valid),    0);
    chk({pfx, "_rd_data"},     32'(bus.rd_data),     0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_frame_end = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_frame_end = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset("rst");

    // EMPTY ignores rd_frame_end
    pulse(1'b0, 1'b1);
    chk("empty_rfe_ready", 32'(bus.frame_ready), 0);
    chk("empty_rfe_bank",  32'(bus.wr_bank),     0);

    // First frame into bank 0, then swap: reader gets bank 0
    wr(7'd5, 12'h0AB);
    pulse(1'b1, 1'b0);
    chk("f1_frame_ready", 32'(bus.frame_ready), 1);
    chk("f1_rd_bank",     32'(bus.rd_bank),     0);
    chk("f1_wr_bank",     32'(bus.wr_bank),     1);
    rd(7'd5);
    chk("f1_rd_valid",    32'(bus.rd_valid), 1);
    chk("f1_rd_5",        32'(bus.rd_data),  32'h0AB);
    tick();
    chk("idle_rd_valid",  32'(bus.rd_valid), 0);
    chk("idle_rd_hold",   32'(bus.rd_data),  32'h0AB);

    // Second frame into bank 1, boundary addresses included
    wr(7'd5,   12'h123);
    wr(7'd99,  12'h777);
    wr(7'd100, 12'h555);
    pulse(1'b1, 1'b0);
    chk("pend_wr_ready",  32'(bus.wr_ready),    0);
    chk("pend_frame_rdy", 32'(bus.frame_ready), 1);
    chk("pend_rd_bank",   32'(bus.rd_bank),     0);
    wr(7'd5, 12'hFFF);      // blocked: would land in bank 1 otherwise
    pulse(1'b0, 1'b1);
    chk("swap2_rd_bank",  32'(bus.rd_bank),  1);
    chk("swap2_wr_ready", 32'(bus.wr_ready), 1);
    rd(7'd5);
    chk("f2_rd_5",        32'(bus.rd_data), 32'h123);
    rd(7'd99);
    chk("f2_rd_99",       32'(bus.rd_data), 32'h777);
    rd(7'd100);
    chk("f2_rd_100_valid", 32'(bus.rd_valid), 1);
    chk("f2_rd_100_zero",  32'(bus.rd_data),  0);

    // FULL with both pulses together: swap, stay FULL
    wr(7'd5, 12'h3C3);      // bank 0
    pulse(1'b1, 1'b1);
    chk("both_rd_bank",   32'(bus.rd_bank),     0);
    chk("both_frame_rdy", 32'(bus.frame_ready), 1);
    chk("both_wr_ready",  32'(bus.wr_ready),    1);
    chk("both_overrun",   32'(bus.overrun),     0);
    rd(7'd5);
    chk("both_rd_5",      32'(bus.rd_data), 32'h3C3);

    // Overrun: PEND then another wr_frame_end
    pulse(1'b1, 1'b0);
    chk("ovr_pre",        32'(bus.overrun),  0);
    pulse(1'b1, 1'b0);
    chk("ovr_set",        32'(bus.overrun),  1);
    chk("ovr_wr_ready",   32'(bus.wr_ready), 0);
    chk("ovr_rd_bank",    32'(bus.rd_bank),  0);
    pulse(1'b0, 1'b1);
    chk("ovr_sticky",     32'(bus.overrun),  1);
    chk("ovr_swap_bank",  32'(bus.rd_bank),  1);

    // Enter PEND, then reset mid-frame
    pulse(1'b1, 1'b0);
    chk("pre_rst_wready", 32'(bus.wr_ready), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst2");

    // Normal frame cycle after reset, then FULL -> EMPTY without swap
    wr(7'd7, 12'h246);
    pulse(1'b1, 1'b0);
    chk("r2_rd_bank",     32'(bus.rd_bank), 0);
    rd(7'd7);
    chk("r2_rd_7",        32'(bus.rd_data), 32'h246);
    pulse(1'b0, 1'b1);
    chk("r2_empty_ready", 32'(bus.frame_ready), 0);
    chk("r2_empty_bank",  32'(bus.rd_bank),     0);
    rd(7'd7);
    chk("r2_stale_rd_7",  32'(bus.rd_data), 32'h246);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
